mx_mem_to_reg: RTL and testbench

Write-back source selector for the CPU datapath. Each cycle it selects the value written to the register file: ALU result, load data from data memory, or link address. Load data is aligned and extended according to the load type. The selected value and its write-enable/address are registered for one cycle in front of the register-file write port.

---
 rtl/mx_mem_to_reg_if.sv | 29 ++
 rtl/mx_mem_to_reg.sv | 83 ++++++++
 tb/tb_mx_mem_to_reg.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/mx_mem_to_reg_if.sv
// Write-back bundle between the memory stage and the register-file write port.
// master drives the stage inputs; slave is the mx_mem_to_reg side.
interface mx_mem_to_reg_if;
    logic        en;
    logic [1:0]  MemToReg;
    logic [31:0] in0;
    logic [31:0] in1;
    logic [31:0] in2;
    logic [2:0]  LoadType;
    logic [1:0]  ByteOff;
    logic        RegWriteIn;
    logic [4:0]  WAddrIn;
    logic [31:0] out;
    logic        RegWrite;
    logic [4:0]  WAddr;
    logic        MisAlign;

    modport master (
        output en, MemToReg, in0, in1, in2,
        output LoadType, ByteOff, RegWriteIn, WAddrIn,
        input  out, RegWrite, WAddr, MisAlign
    );

    modport slave (
        input  en, MemToReg, in0, in1, in2,
        input  LoadType, ByteOff, RegWriteIn, WAddrIn,
        output out, RegWrite, WAddr, MisAlign
    );
endinterface

// File: rtl/mx_mem_to_reg.sv
// Write-back source select with load alignment/extension,
// registered once in front of the register-file write port.
module mx_mem_to_reg (
    input  logic           clk,
    input  logic           rst_n,
    mx_mem_to_reg_if.slave bus
);
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;
    logic [31:0] wb_data;
    logic        sel_ld;
    logic        sel_link;
    logic        sel_alu;
    logic        is_byte;
    logic        is_half;
    logic        is_word;
    logic        mis;
    logic        wr;

    assign sel_ld   = (bus.MemToReg == 2'b01);
    assign sel_link = (bus.MemToReg == 2'b10);
    assign sel_alu  = !sel_ld && !sel_link;

    assign is_byte = (bus.LoadType == 3'b001) || (bus.LoadType == 3'b010);
    assign is_half = (bus.LoadType == 3'b011) || (bus.LoadType == 3'b100);
    assign is_word = !is_byte && !is_half;

    always_comb begin
        ld_byte = bus.in1[7:0];
        unique case (bus.ByteOff)
            2'b00: ld_byte = bus.in1[7:0];
            2'b01: ld_byte = bus.in1[15:8];
            2'b10: ld_byte = bus.in1[23:16];
            2'b11: ld_byte = bus.in1[31:24];
            default: ld_byte = bus.in1[7:0];
        endcase
    end

    // Misaligned halfwords still take the lane picked by ByteOff[1].
    assign ld_half = bus.ByteOff[1] ? bus.in1[31:16] : bus.in1[15:0];

    always_comb begin
        ld_data = bus.in1;
        unique case (bus.LoadType)
            3'b001: ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b010: ld_data = {24'h0, ld_byte};
            3'b011: ld_data = {{16{ld_half[15]}}, ld_half};
            3'b100: ld_data = {16'h0, ld_half};
            default: ld_data = bus.in1;
        endcase
    end

    always_comb begin
        wb_data = bus.in0;
        unique case (1'b1)
            sel_ld:   wb_data = ld_data;
            sel_link: wb_data = bus.in2;
            sel_alu:  wb_data = bus.in0;
            default:  wb_data = bus.in0;
        endcase
    end

    assign mis = sel_ld &&
                 ((is_word && (bus.ByteOff != 2'b00)) ||
                  (is_half && bus.ByteOff[0]));

    assign wr = bus.RegWriteIn && (bus.WAddrIn != 5'd0) && !mis;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out      <= 32'h0;
            bus.RegWrite <= 1'b0;
            bus.WAddr    <= 5'd0;
            bus.MisAlign <= 1'b0;
        end else if (bus.en) begin
            bus.out      <= wb_data;
            bus.RegWrite <= wr;
            bus.WAddr    <= bus.WAddrIn;
            bus.MisAlign <= mis;
        end
    end
endmodule

// File: tb/tb_mx_mem_to_reg.sv
// Scoreboard bench for mx_mem_to_reg: expected write-back
// results are queued at drive time and checked after each edge.
module tb_mx_mem_to_reg;
    typedef struct packed {
        logic [31:0] data;
        logic        we;
        logic [4:0]  wa;
        logic        mis;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;
    exp_t held;
    exp_t sb[$];

    mx_mem_to_reg_if bus ();

    mx_mem_to_reg dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input exp_t prev);
        exp_t        r;
        logic [31:0] w;
        logic [31:0] b;
        logic [31:0] h;
        logic        m;
        r = prev;
        if (!bus.en) return r;
        w = bus.in1;
        b = (w >> (8 * bus.ByteOff)) & 32'hFF;
        h = bus.ByteOff[1] ? (w >> 16) : (w & 32'hFFFF);
        m = 1'b0;
        if (bus.MemToReg == 2'b01) begin
            case (bus.LoadType)
                3'd1: r.data = (b >= 32'h80) ? (b | 32'hFFFFFF00) : b;
                3'd2: r.data = b;
                3'd3: r.data = (h >= 32'h8000) ? (h | 32'hFFFF0000) : h;
                3'd4: r.data = h;
                default: r.data = w;
            endcase
            if (bus.LoadType == 3'd3 || bus.LoadType == 3'd4)
                m = bus.ByteOff[0];
            else if (bus.LoadType != 3'd1 && bus.LoadType != 3'd2)
                m = (bus.ByteOff != 2'b00);
        end else if (bus.MemToReg == 2'b10) begin
            r.data = bus.in2;
        end else begin
            r.data = bus.in0;
        end
        r.mis = m;
        r.wa  = bus.WAddrIn;
        r.we  = bus.RegWriteIn && (bus.WAddrIn != 0) && !m;
        return r;
    endfunction

    task automatic cyc(input string tag);
        exp_t e;
        held = model(held);
        sb.push_back(held);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, ".out"}, bus.out, e.data);
            chk({tag, ".we"}, {31'h0, bus.RegWrite}, {31'h0, e.we});
            chk({tag, ".wa"}, {27'h0, bus.WAddr}, {27'h0, e.wa});
            chk({tag, ".mis"}, {31'h0, bus.MisAlign}, {31'h0, e.mis});
        end
        @(negedge clk);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".out"}, bus.out, 32'h0);
        chk({tag, ".we"}, {31'h0, bus.RegWrite}, 32'h0);
        chk({tag, ".wa"}, {27'h0, bus.WAddr}, 32'h0);
        chk({tag, ".mis"}, {31'h0, bus.MisAlign}, 32'h0);
    endtask

    task automatic ld(input logic [2:0] lt, input logic [1:0] bo,
                      input logic [31:0] want, input string tag);
        bus.MemToReg = 2'b01;
        bus.in1      = 32'h80FF7F01;
        bus.LoadType = lt;
        bus.ByteOff  = bo;
        cyc(tag);
        chk({tag, ".lit"}, bus.out, want);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        held  = '0;
        rst_n = 1'b1;
        bus.en         = 1'b1;
        bus.MemToReg   = 2'b00;
        bus.in0        = 32'hDEADBEEF;
        bus.in1        = 32'hCAFEF00D;
        bus.in2        = 32'h00001004;
        bus.LoadType   = 3'b000;
        bus.ByteOff    = 2'b00;
        bus.RegWriteIn = 1'b1;
        bus.WAddrIn    = 5'd9;

        // capture something nonzero, then reset between edges
        @(negedge clk);
        cyc("pre");
        #2 rst_n = 1'b0;
        #1 chk_zero("rst_async");
        held = '0;
        @(posedge clk);
        #1 chk_zero("rst_hold");
        @(negedge clk);
        rst_n = 1'b1;

        bus.in0     = 32'h12345678;
        bus.WAddrIn = 5'd3;
        cyc("first");
        chk("first.lit", bus.out, 32'h12345678);

        bus.in0 = 32'hA;
        bus.in1 = 32'hB;
        bus.in2 = 32'hC;
        for (int i = 0; i < 4; i++) begin
            bus.MemToReg = 2'(i);
            cyc($sformatf("sel%0d", i));
        end

        ld(3'b001, 2'b00, 32'h00000001, "sb0");
        ld(3'b001, 2'b01, 32'h0000007F, "sb1");
        ld(3'b001, 2'b10, 32'hFFFFFFFF, "sb2");
        ld(3'b001, 2'b11, 32'hFFFFFF80, "sb3");
        ld(3'b010, 2'b11, 32'h00000080, "ub3");
        ld(3'b011, 2'b10, 32'hFFFF80FF, "sh2");
        ld(3'b100, 2'b10, 32'h000080FF, "uh2");
        ld(3'b011, 2'b00, 32'h00007F01, "sh0");
        ld(3'b011, 2'b01, 32'h00007F01, "shmis");
        ld(3'b111, 2'b00, 32'h80FF7F01, "wrsv");

        bus.LoadType   = 3'b000;
        bus.ByteOff    = 2'b01;
        bus.RegWriteIn = 1'b1;
        bus.WAddrIn    = 5'd5;
        cyc("wmis");
        chk("wmis.flag", {31'h0, bus.MisAlign}, 32'h1);
        chk("wmis.we", {31'h0, bus.RegWrite}, 32'h0);
        bus.MemToReg = 2'b00;
        cyc("walu");
        chk("walu.flag", {31'h0, bus.MisAlign}, 32'h0);
        chk("walu.we", {31'h0, bus.RegWrite}, 32'h1);

        bus.in0 = 32'h55;
        cyc("cap55");
        bus.en  = 1'b0;
        bus.in0 = 32'h66;
        for (int i = 0; i < 3; i++) begin
            cyc($sformatf("hold%0d", i));
            chk("hold.lit", bus.out, 32'h55);
        end
        bus.en      = 1'b1;
        bus.WAddrIn = 5'd0;
        cyc("r0");
        chk("r0.we", {31'h0, bus.RegWrite}, 32'h0);
        chk("r0.out", bus.out, 32'h66);

        for (int i = 0; i < 40; i++) begin
            bus.en         = ($urandom_range(0, 3) != 0);
            bus.MemToReg   = 2'($urandom_range(0, 3));
            bus.in0        = $urandom;
            bus.in1        = $urandom;
            bus.in2        = $urandom;
            bus.LoadType   = 3'($urandom_range(0, 7));
            bus.ByteOff    = 2'($urandom_range(0, 3));
            bus.RegWriteIn = 1'($urandom_range(0, 1));
            bus.WAddrIn    = 5'($urandom_range(0, 31));
            cyc($sformatf("rnd%0d", i));
        end

        bus.en = 1'b1;
        #2 rst_n = 1'b0;
        #1 chk_zero("rst_mid");
        @(negedge clk);
        rst_n = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
